hazard_stall_controller: RTL and testbench

Sequences stalls, bubbles and branch flushes for the 5-stage pipeline. It sits beside the ID stage, compares the ID instruction's source registers against the EX and MEM producers, and drives the PC / IF-ID write enables, the ID-EX bubble and the IF-ID flush. It assumes ID-stage branch compares are forwarded only from EX/MEM ALU results and that EX-stage ALU operands are forwarded. It stalls only where forwarding cannot cover the dependency, holds each stall for a fixed, pre-computed length, and keeps saturating performance counters.

---
 rtl/hazard_stall_controller.sv | 154 +++++++++++++++
 tb/tb_hazard_stall_controller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer for a 5-stage pipeline with ID-stage branch resolution.
// It compares ID sources with the EX/MEM producers, drives stalls, bubbles and flushes, and keeps saturating counters.
module hazard_stall_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 freeze_i,
  input  logic                 id_valid_i,
  input  logic                 id_is_branch_i,
  input  logic                 id_uses_rs_i,
  input  logic                 id_uses_rt_i,
  input  logic [4:0]           id_rs_addr_i,
  input  logic [4:0]           id_rt_addr_i,
  input  logic                 branch_taken_i,
  input  logic                 ex_reg_write_i,
  input  logic                 ex_mem_read_i,
  input  logic [4:0]           ex_write_addr_i,
  input  logic                 mem_reg_write_i,
  input  logic                 mem_mem_read_i,
  input  logic [4:0]           mem_write_addr_i,
  output logic                 pc_write_o,
  output logic                 if_id_write_o,
  output logic                 id_ex_bubble_o,
  output logic                 if_id_flush_o,
  output logic                 stall_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           rem_q, rem_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic       ex_rs_match, ex_rt_match, mem_rs_match, mem_rt_match;
  logic       ex_match, ex_load_match, mem_load_match;
  logic [1:0] stall_len;
  logic       stall_inc, flush_inc;

  // Register $0 is hard-wired to zero, so it never creates a dependency.
  assign ex_rs_match  = id_uses_rs_i && (id_rs_addr_i != 5'd0) && ex_reg_write_i
                        && (id_rs_addr_i == ex_write_addr_i);
  assign ex_rt_match  = id_uses_rt_i && (id_rt_addr_i != 5'd0) && ex_reg_write_i
                        && (id_rt_addr_i == ex_write_addr_i);
  assign mem_rs_match = id_uses_rs_i && (id_rs_addr_i != 5'd0) && mem_reg_write_i
                        && (id_rs_addr_i == mem_write_addr_i);
  assign mem_rt_match = id_uses_rt_i && (id_rt_addr_i != 5'd0) && mem_reg_write_i
                        && (id_rt_addr_i == mem_write_addr_i);

  assign ex_match       = ex_rs_match || ex_rt_match;
  assign ex_load_match  = ex_match && ex_mem_read_i;
  assign mem_load_match = (mem_rs_match || mem_rt_match) && mem_mem_read_i;

  // Rules are ordered by decreasing length, so the first hit is also the largest L.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    stall_len = 2'd0;
    if (id_valid_i) begin
      if (id_is_branch_i) begin
        if (ex_load_match)       stall_len = 2'd2;
        else if (ex_match)       stall_len = 2'd1;
        else if (mem_load_match) stall_len = 2'd1;
      end else if (ex_load_match) begin
        stall_len = 2'd1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rem_d          = rem_q;
    pc_write_o     = 1'b1;
    if_id_write_o  = 1'b1;
    id_ex_bubble_o = 1'b0;
    if_id_flush_o  = 1'b0;
    stall_o        = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    unique case (state_q)
      RUN: begin
        if (stall_len != 2'd0) begin
          stall_o        = 1'b1;
          pc_write_o     = 1'b0;
          if_id_write_o  = 1'b0;
          id_ex_bubble_o = 1'b1;
          stall_inc      = 1'b1;
          if (stall_len == 2'd2) begin
            state_d = STALL;
            rem_d   = 2'd1;
          end
        end else if (id_is_branch_i && branch_taken_i) begin
          if_id_flush_o = 1'b1;
          flush_inc     = 1'b1;
        end
      end
      STALL: begin
        // Hazards are not re-examined here; the length was fixed on entry.
        stall_o        = 1'b1;
        pc_write_o     = 1'b0;
        if_id_write_o  = 1'b0;
        id_ex_bubble_o = 1'b1;
        stall_inc      = 1'b1;
        rem_d          = rem_q - 2'd1;
        if (rem_q <= 2'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // Freeze overrides every enable but leaves stall_o reporting the pending stall.
    if (freeze_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b0;
      if_id_flush_o  = 1'b0;
      state_d        = state_q;
      rem_d          = rem_q;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!rst_n_i) begin
      state_q     <= RUN;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: load-use, branch stalls, false-stall cases,
// freeze, async reset mid-stall and counter saturation (4-bit counters).
module tb_hazard_stall_controller;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          freeze_i, id_valid_i, id_is_branch_i, id_uses_rs_i, id_uses_rt_i;
  logic [4:0]    id_rs_addr_i, id_rt_addr_i;
  logic          branch_taken_i;
  logic          ex_reg_write_i, ex_mem_read_i;
  logic [4:0]    ex_write_addr_i;
  logic          mem_reg_write_i, mem_mem_read_i;
  logic [4:0]    mem_write_addr_i;
  logic          pc_write_o, if_id_write_o, id_ex_bubble_o, if_id_flush_o, stall_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  hazard_stall_controller #(.CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .freeze_i(freeze_i),
    .id_valid_i(id_valid_i), .id_is_branch_i(id_is_branch_i),
    .id_uses_rs_i(id_uses_rs_i), .id_uses_rt_i(id_uses_rt_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rt_addr_i(id_rt_addr_i),
    .branch_taken_i(branch_taken_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_write_addr_i(ex_write_addr_i),
    .mem_reg_write_i(mem_reg_write_i), .mem_mem_read_i(mem_mem_read_i),
    .mem_write_addr_i(mem_write_addr_i),
    .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
    .id_ex_bubble_o(id_ex_bubble_o), .if_id_flush_o(if_id_flush_o),
    .stall_o(stall_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Settle combinational outputs, then compare pc/if_id/bubble/flush/stall.
  task automatic outs(input string tag, input logic pc, input logic ifid,
                      input logic bub, input logic fl, input logic st);
    #1;
    check({tag, ".pc_write"},    32'(pc_write_o),     32'(pc));
    check({tag, ".if_id_write"}, 32'(if_id_write_o),  32'(ifid));
    check({tag, ".bubble"},      32'(id_ex_bubble_o), 32'(bub));
    check({tag, ".flush"},       32'(if_id_flush_o),  32'(fl));
    check({tag, ".stall"},       32'(stall_o),        32'(st));
  endtask

  task automatic cnts(input string tag, input int sc, input int fc);
    check({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(sc));
    check({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(fc));
  endtask

  task automatic idle();
    freeze_i = 0; id_valid_i = 0; id_is_branch_i = 0; id_uses_rs_i = 0; id_uses_rt_i = 0;
    id_rs_addr_i = 0; id_rt_addr_i = 0; branch_taken_i = 0;
    ex_reg_write_i = 0; ex_mem_read_i = 0; ex_write_addr_i = 0;
    mem_reg_write_i = 0; mem_mem_read_i = 0; mem_write_addr_i = 0;
  endtask

  task automatic set_ex(input logic wr, input logic rd, input logic [4:0] a);
    ex_reg_write_i = wr; ex_mem_read_i = rd; ex_write_addr_i = a;
  endtask

  task automatic set_mem(input logic wr, input logic rd, input logic [4:0] a);
    mem_reg_write_i = wr; mem_mem_read_i = rd; mem_write_addr_i = a;
  endtask

  task automatic set_id(input logic br, input logic urs, input logic [4:0] rs,
                        input logic urt, input logic [4:0] rt, input logic taken);
    id_valid_i = 1; id_is_branch_i = br; id_uses_rs_i = urs; id_rs_addr_i = rs;
    id_uses_rt_i = urt; id_rt_addr_i = rt; branch_taken_i = taken;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n_i = 0;
    step();
    rst_n_i = 1;
  endtask

  initial begin
    idle();
    rst_n_i = 0;
    #2;
    outs("reset", 1, 1, 0, 0, 0);
    cnts("reset", 0, 0);
    step();
    rst_n_i = 1;

    // Load-use: lw $5 in EX, add reading $5.
    set_ex(1, 1, 5'd5); set_id(0, 1, 5'd5, 0, 5'd0, 0);
    outs("lu.stall", 0, 0, 1, 0, 1);
    step();
    set_ex(0, 0, 5'd0); set_mem(1, 1, 5'd5);
    outs("lu.resume", 1, 1, 0, 0, 0);
    cnts("lu", 1, 0);

    // Branch on a load in EX, taken: two stall cycles then one flush.
    do_reset();
    set_ex(1, 1, 5'd3); set_id(1, 0, 5'd0, 1, 5'd3, 1);
    outs("bl.c1", 0, 0, 1, 0, 1);
    step();
    set_ex(0, 0, 5'd0); set_mem(1, 1, 5'd3);
    outs("bl.c2", 0, 0, 1, 0, 1);
    cnts("bl.c2", 1, 0);
    step();
    set_mem(0, 0, 5'd0);
    outs("bl.flush", 1, 1, 0, 1, 0);
    step();
    idle();
    outs("bl.after", 1, 1, 0, 0, 0);
    cnts("bl", 2, 1);

    // No false stalls: MEM ALU producer, and $0 destination.
    do_reset();
    set_mem(1, 0, 5'd7); set_id(1, 1, 5'd7, 0, 5'd0, 0);
    outs("nf.mem_alu", 1, 1, 0, 0, 0);
    idle();
    set_ex(1, 1, 5'd0); set_id(0, 1, 5'd0, 1, 5'd0, 0);
    outs("nf.r0", 1, 1, 0, 0, 0);
    set_ex(1, 1, 5'd9); set_id(0, 0, 5'd9, 0, 5'd0, 0);
    outs("nf.unused", 1, 1, 0, 0, 0);
    set_ex(1, 1, 5'd9); set_id(0, 1, 5'd9, 0, 5'd0, 0); id_valid_i = 0;
    outs("nf.invalid", 1, 1, 0, 0, 0);

    // Branch L=1 cases stay in RUN: next cycle with no hazard is free.
    idle();
    set_ex(1, 0, 5'd4); set_id(1, 1, 5'd4, 0, 5'd0, 1);
    outs("b_exalu.c1", 0, 0, 1, 0, 1);
    step();
    idle(); set_id(1, 1, 5'd4, 0, 5'd0, 0);
    outs("b_exalu.c2", 1, 1, 0, 0, 0);
    idle();
    set_mem(1, 1, 5'd6); set_id(1, 0, 5'd0, 1, 5'd6, 0);
    outs("b_memld.c1", 0, 0, 1, 0, 1);
    step();
    idle();
    outs("b_memld.c2", 1, 1, 0, 0, 0);
    // rs matches EX ALU, rt matches MEM load: L = 1.
    set_ex(1, 0, 5'd8); set_mem(1, 1, 5'd9); set_id(1, 1, 5'd8, 1, 5'd9, 0);
    outs("b_both.c1", 0, 0, 1, 0, 1);
    step();
    idle();
    outs("b_both.c2", 1, 1, 0, 0, 0);
    cnts("b_l1", 3, 0);

    // Freeze in the STALL cycle holds rem and counters.
    do_reset();
    set_ex(1, 1, 5'd3); set_id(1, 0, 5'd0, 1, 5'd3, 0);
    outs("fz.c1", 0, 0, 1, 0, 1);
    step();
    idle(); freeze_i = 1;
    outs("fz.frozen", 0, 0, 0, 0, 1);
    step();
    outs("fz.frozen2", 0, 0, 0, 0, 1);
    cnts("fz.frozen", 1, 0);
    freeze_i = 0;
    outs("fz.resume", 0, 0, 1, 0, 1);
    step();
    outs("fz.done", 1, 1, 0, 0, 0);
    cnts("fz", 2, 0);
    // Freeze in RUN blocks a taken-branch flush.
    set_id(1, 0, 5'd0, 0, 5'd0, 1); freeze_i = 1;
    outs("fz.run_br", 0, 0, 0, 0, 0);
    step();
    cnts("fz.run_br", 2, 0);
    idle();

    // Async reset between edges while in STALL.
    do_reset();
    set_ex(1, 1, 5'd3); set_id(1, 1, 5'd3, 0, 5'd0, 1);
    outs("ar.c1", 0, 0, 1, 0, 1);
    step();
    idle();
    outs("ar.stall", 0, 0, 1, 0, 1);
    cnts("ar.pre", 1, 0);
    #1;
    rst_n_i = 0;
    outs("ar.reset", 1, 1, 0, 0, 0);
    cnts("ar.reset", 0, 0);
    step();
    rst_n_i = 1;

    // Saturation: 20 load-use stalls on 4-bit counter.
    set_ex(1, 1, 5'd5); set_id(0, 1, 5'd5, 0, 5'd0, 0);
    repeat (20) step();
    outs("sat.still", 0, 0, 1, 0, 1);
    cnts("sat", 15, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
